// File: rtl/pulse_gen_pkg.sv
// Shared types and legacy constants for the programmable pulse train generator.
package pulse_gen_pkg;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} pg_state_t;
  typedef enum logic {FREE_RUN, BURST} pg_mode_t;

  // Legacy NES clock holder waveform: 12 high, 13 low, 8 clocks per poll.
  localparam int DEF_HIGH_LEN   = 12;
  localparam int DEF_LOW_LEN    = 13;
  localparam int NES_CLK_PULSES = 8;

endpackage

// File: rtl/phase_counter.sv
// Down-counter timing one HIGH or LOW phase; tc marks the last cycle of the phase.
module phase_counter #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  // Holds at zero between phases so it never wraps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse train: free-running or counted bursts, with rise/fall/done strobes.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W = 10,
  parameter int NP_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [NP_W-1:0]  n_pulses,
  output logic             q,
  output logic             rise,
  output logic             fall,
  output logic             busy,
  output logic             done,
  output logic [NP_W-1:0]  pulse_idx
);

  pg_state_t        state, state_next;
  pg_mode_t         mode_r;
  logic [CNT_W-1:0] low_len_r;
  logic [NP_W-1:0]  n_pulses_r;
  logic [NP_W-1:0]  idx_next;
  logic             load, tc, latch_cfg, latch_low, done_next;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] high_ld, low_ld;

  // A zero length behaves as one cycle, i.e. counter load value 0.
  assign high_ld = (high_len == '0) ? '0 : high_len - CNT_W'(1);
  assign low_ld  = (low_len_r == '0) ? '0 : low_len_r - CNT_W'(1);

  phase_counter #(.CNT_W(CNT_W)) u_phase (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .tc       (tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_val   = '0;
    latch_cfg  = 1'b0;
    latch_low  = 1'b0;
    done_next  = 1'b0;
    idx_next   = pulse_idx;
    unique case (state)
      IDLE: begin
        idx_next = '0;
        if ((mode == 1'b0 && en) || (mode == 1'b1 && start && n_pulses != '0)) begin
          state_next = HIGH;
          load       = 1'b1;
          load_val   = high_ld;
          latch_cfg  = 1'b1;
          latch_low  = 1'b1;
        end else if (mode == 1'b1 && start) begin
          done_next = 1'b1;
        end
      end
      HIGH: begin
        if (tc) begin
          state_next = LOW;
          load       = 1'b1;
          load_val   = low_ld;
        end
      end
      LOW: begin
        if (tc) begin
          if ((mode_r == FREE_RUN && !en) ||
              (mode_r == BURST && pulse_idx == n_pulses_r - NP_W'(1))) begin
            state_next = IDLE;
            idx_next   = '0;
            done_next  = (mode_r == BURST);
          end else begin
            state_next = HIGH;
            load       = 1'b1;
            load_val   = high_ld;
            latch_low  = 1'b1;
            idx_next   = pulse_idx + NP_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Configuration captured at launch; the LOW length is re-captured at every HIGH entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_r     <= FREE_RUN;
      n_pulses_r <= '0;
      low_len_r  <= '0;
    end else begin
      if (latch_cfg) begin
        mode_r     <= pg_mode_t'(mode);
        n_pulses_r <= n_pulses;
      end
      if (latch_low) low_len_r <= low_len;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q         <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_idx <= '0;
    end else begin
      q         <= (state_next == HIGH);
      rise      <= (state_next == HIGH) && (state != HIGH);
      fall      <= (state == HIGH) && (state_next == LOW);
      busy      <= (state_next != IDLE);
      done      <= done_next;
      pulse_idx <= idx_next;
    end
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Parametrised successor to the fixed 12-high/13-low NES clock holder. Generates a programmable-duty pulse train on `q`, either free-running or as a counted burst launched by `start`. Burst mode drives the NES controller latch/clock sequencing: for example, 8 clock pulses per poll, with `rise`/`fall` strobes the receiver uses to sample serial data.

## Interface
- `CNT_W`, 10: width of the phase-length inputs and the internal phase counter.
- `NP_W`, 5: width of the pulse-count input and the `pulse_idx` output.
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset (asserted when 0); release is synchronous to `clk`.
- `mode` in 1: 0 = free-run, 1 = burst. Latched at launch.
- `en` in 1: free-run enable. Level-sensitive.
- `start` in 1: burst launch request, sampled only in IDLE with `mode`=1.
- `high_len` in CNT_W: HIGH phase length in cycles. 0 is treated as 1.
- `low_len` in CNT_W: LOW phase length in cycles. 0 is treated as 1.
- `n_pulses` in NP_W: number of pulses per burst.
- `q` out 1: pulse output, registered.
- `rise` out 1: one-cycle strobe on the first cycle `q`=1 of each pulse.
- `fall` out 1: one-cycle strobe on the first cycle `q`=0 after a pulse.
- `busy` out 1: high while in the HIGH or LOW state.
- `done` out 1: one-cycle strobe when a burst ends.
- `pulse_idx` out NP_W: 0-based index of the current pulse.

## Operation
- States: IDLE, HIGH, LOW.
- Reset values: state IDLE; `q`, `rise`, `fall`, `busy`, `done`, `pulse_idx` and the counter all 0.
- IDLE → HIGH: taken when (`mode`=0 and `en`=1) or (`mode`=1 and `start`=1 and `n_pulses`≠0).
  - On this transition, latch `mode`, `high_len`, `low_len` and `n_pulses`.
- Phase lengths are re-latched at every LOW→HIGH entry. Changing them mid-phase never shortens or lengthens the current phase.
- HIGH: `q`=1 for H = max(`high_len`,1) cycles, then go to LOW.
- LOW: `q`=0 for L = max(`low_len`,1) cycles. At the end of LOW:
  - Free-run with `en`=1: go to HIGH and increment `pulse_idx`, which wraps modulo 2^NP_W.
  - Free-run with `en`=0: go to IDLE (graceful stop, no runt pulse).
  - Burst with `pulse_idx` = N−1: go to IDLE and assert `done`.
  - Burst otherwise: go to HIGH and increment `pulse_idx`.
- `en` deasserting during HIGH still completes that HIGH phase and the following LOW phase.
- In burst mode, `en` is ignored.
- `start` while `busy` is ignored, and is not queued.
- `start` with `n_pulses`=0 in IDLE: `done` pulses the next cycle. `busy` stays 0 and `q` stays 0.
- `pulse_idx` returns to 0 on entry to IDLE.
- Reset asserted mid-operation: state and outputs go to their reset values immediately (asynchronously). No `done` is generated.
- Counter: a CNT_W-bit down-counter, loaded with length−1 on phase entry. The phase ends at count 0. No overflow is possible.

## Timing
- Launch sampled at edge t: `q`=1, `rise`=1 and `busy`=1 from cycle t+1.
- Period is exactly H+L cycles. Duty is H/(H+L).
- `fall`=1 on cycle t+1+H+k(H+L).
- Burst end: after N(H+L) cycles, the following cycle has `busy`=0 and `done`=1.
  - Earliest relaunch: `start` sampled in that same `done` cycle.
- Free-run with `en` held: back-to-back pulses, no idle gap.
- Defaults H=12, L=13 reproduce the legacy 25-cycle waveform.

## Structure
- Package `pulse_gen_pkg`:
  - `typedef enum logic [1:0] {IDLE, HIGH, LOW} pg_state_t`
  - `typedef enum logic {FREE_RUN, BURST} pg_mode_t`
  - Constants `DEF_HIGH_LEN`=12, `DEF_LOW_LEN`=13, `NES_CLK_PULSES`=8.
- One sub-module, `phase_counter`:
  - Parameter CNT_W.
  - Ports: `load`, `load_val`, terminal-count output `tc`.
  - Shares the same clock and reset.
- Top level holds the FSM, the latched configuration and the output registers.

## Test plan
- Free-run: `mode`=0, `en`=1, H=12, L=13 for 100 cycles.
  - Required: `q` high 12 / low 13, period 25. `rise` at t+1, t+26, t+51. `pulse_idx` 0,1,2,3.
- Burst: `mode`=1, N=8, H=2, L=3, one-cycle `start` at t.
  - Required: 8 pulses, `busy` t+1..t+40, `done`=1 only at t+41.
  - `start` pulsed at t+10 changes nothing.
- Zero handling:
  - `high_len`=0, `low_len`=0: period 2, 50% duty.
  - `start` with N=0: `done` at t+1, `q` never rises.
- Graceful stop: in free-run, drop `en` 3 cycles into HIGH (H=4, L=4).
  - Required: HIGH and LOW both complete, IDLE after 8 cycles total, no partial pulse.
  - Change `high_len` mid-HIGH: takes effect on the next pulse only.
- Reset: drive `reset`=0 mid-burst on pulse 5.
  - Required: `q`, `busy`, `pulse_idx` = 0 within the same cycle, no `done`.
  - After release, a new `start` produces a full N-pulse burst.
- Wrap: NP_W=3, free-run for 10 pulses.
  - Required: `pulse_idx` sequence 0..7,0,1 with no disturbance to `q`.
